// File: rtl/sao_stat_pkg.sv
// SAO edge-offset statistics: shared types and width helpers.
// Imported by the accumulator top and its per-category bin.
package sao_stat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_t;

  localparam int CAT_W = 3;
  localparam logic [CAT_W-1:0] CAT_NONE = '0;
  localparam logic [CAT_W-1:0] CAT_FIRST = 3'd1;

  function automatic int sum_w(input int dcb, input int cl);
    return dcb + 1 + 2 * cl;
  endfunction

  function automatic int cnt_w(input int cl);
    return 2 * cl + 1;
  endfunction

endpackage

// File: rtl/sao_stat_bin.sv
// One EO category accumulator: signed diff sum and pixel count.
// clr restarts the bin; add_en together with clr loads one pixel.
module sao_stat_bin #(
  parameter int dw = 5,
  parameter int sw = 17,
  parameter int cw = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic signed [dw-1:0] diff,
  output logic signed [sw-1:0] sum,
  output logic [cw-1:0]        cnt
);

  logic signed [sw-1:0] diff_ext;

  assign diff_ext = {{(sw-dw){diff[dw-1]}}, diff};

  // Sum/count register; a clear can carry its own pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (clr) begin
      sum <= add_en ? diff_ext : '0;
      cnt <= add_en ? cw'(1) : '0;
    end else if (add_en) begin
      sum <= sum + diff_ext;
      cnt <= cnt + cw'(1);
    end
  end

endmodule

// File: rtl/sao_stat_accum.sv
// SAO EO statistic accumulator: bins diffs per category over a CTB,
// then drains one beat per category. SAO_STAT_PIXCNT_EN adds out_total.
module sao_stat_accum
  import sao_stat_pkg::*;
#(
  parameter int diff_clip_bit = 4,
  parameter int ctb_log2      = 6,
  parameter int num_cat       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [CAT_W-1:0]         in_cat,
  input  logic signed [diff_clip_bit:0] in_diff,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CAT_W-1:0]         out_cat,
  output logic signed [sum_w(diff_clip_bit, ctb_log2)-1:0] out_sum,
  output logic [cnt_w(ctb_log2)-1:0] out_cnt
`ifdef SAO_STAT_PIXCNT_EN
  ,
  output logic [cnt_w(ctb_log2)-1:0] out_total
`endif
);

  localparam int DW = diff_clip_bit + 1;
  localparam int SW = sum_w(diff_clip_bit, ctb_log2);
  localparam int CW = cnt_w(ctb_log2);

  state_t state, state_nxt;

  logic xfer;
  logic accept;
  logic clr;
  logic beat;
  logic beat_end;
  logic [num_cat-1:0] hit;

  logic signed [SW-1:0] diff_ext;
  logic signed [SW-1:0] bin_sum [num_cat];
  logic [CW-1:0]        bin_cnt [num_cat];

  logic signed [SW-1:0] sel_sum;
  logic [CW-1:0]        sel_cnt;
  logic signed [SW-1:0] first_sum;
  logic [CW-1:0]        first_cnt;

  assign in_ready  = (state != DRAIN);
  assign out_valid = (state == DRAIN);
  assign xfer      = in_valid && in_ready;
  assign accept    = xfer && (in_first || state == ACCUM);
  assign clr       = accept && in_first;
  assign beat      = out_valid && out_ready;
  assign beat_end  = beat && (out_cat == CAT_W'(num_cat));
  assign diff_ext  = {{(SW-DW){in_diff[DW-1]}}, in_diff};

  for (genvar g = 0; g < num_cat; g++) begin : g_bin
    assign hit[g] = accept && (in_cat == CAT_W'(g + 1));

    sao_stat_bin #(
      .dw (DW),
      .sw (SW),
      .cw (CW)
    ) u_bin (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .add_en (hit[g]),
      .diff   (in_diff),
      .sum    (bin_sum[g]),
      .cnt    (bin_cnt[g])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = in_last ? DRAIN : ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (beat_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bin feeding the next drain beat (out_cat is 0-based index there).
  always_comb begin
    sel_sum = '0;
    sel_cnt = '0;
    for (int i = 0; i < num_cat; i++) begin
      if (out_cat == CAT_W'(i)) begin
        sel_sum = bin_sum[i];
        sel_cnt = bin_cnt[i];
      end
    end
  end

  // Value bin 1 takes on this edge, so beat 1 is ready one cycle later.
  always_comb begin
    first_sum = clr ? '0 : bin_sum[0];
    first_cnt = clr ? '0 : bin_cnt[0];
    if (hit[0]) begin
      first_sum = first_sum + diff_ext;
      first_cnt = first_cnt + CW'(1);
    end
  end

  // Registered drain beat: load on last pixel, advance per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cat <= CAT_NONE;
      out_sum <= '0;
      out_cnt <= '0;
    end else if (accept && in_last) begin
      out_cat <= CAT_FIRST;
      out_sum <= first_sum;
      out_cnt <= first_cnt;
    end else if (beat_end) begin
      out_cat <= CAT_NONE;
      out_sum <= '0;
      out_cnt <= '0;
    end else if (beat) begin
      out_cat <= out_cat + CAT_W'(1);
      out_sum <= sel_sum;
      out_cnt <= sel_cnt;
    end
  end

`ifdef SAO_STAT_PIXCNT_EN
  logic [CW-1:0] tot;

  // Accepted transfers of the current CTB, any category.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tot <= '0;
    else if (clr)    tot <= CW'(1);
    else if (accept) tot <= tot + CW'(1);
  end

  assign out_total = tot;
`endif

endmodule
